// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction in flight; the owner keeps the slave until its R or B response completes.
module axi_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    // M0: instruction fetch, read only
    input  logic                  m0_arvalid,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [2:0]            m0_arsize,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic                  m0_rready,
    // M1: data port, read and write
    input  logic                  m1_arvalid,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [2:0]            m1_arsize,
    output logic                  m1_arready,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    input  logic                  m1_rready,
    input  logic                  m1_awvalid,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    output logic                  m1_awready,
    input  logic                  m1_wvalid,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_wready,
    output logic                  m1_bvalid,
    output logic [1:0]            m1_bresp,
    input  logic                  m1_bready,
    // Slave port
    output logic                  s_arvalid,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [2:0]            s_arsize,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    output logic                  s_rready,
    output logic                  s_awvalid,
    output logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    output logic                  s_bready,
    // Status
    output logic                  busy,
    output logic [1:0]            grant
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0_AR = 3'd1,
        M0_R  = 3'd2,
        M1_AR = 3'd3,
        M1_R  = 3'd4,
        M1_AW = 3'd5,
        M1_B  = 3'd6
    } state_t;

    state_t state, state_nxt;
    logic   last_m1, last_m1_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;

    logic   req0, req1, wr1, pick1;
    logic   aw_ok, w_ok;

    // State and write-progress registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            last_m1 <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    // Arbitration request decode; M1 wins outright in fixed mode or when M0 was served last
    assign req0  = m0_arvalid;
    assign wr1   = m1_awvalid & m1_wvalid;
    assign req1  = m1_arvalid | wr1;
    assign pick1 = req1 & (~req0 | (RR == 1'b0) | ~last_m1);

    // Next state and channel routing
    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_ok       = 1'b0;
        w_ok        = 1'b0;

        m0_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rdata    = s_rdata;
        m0_rresp    = s_rresp;
        m1_arready  = 1'b0;
        m1_rvalid   = 1'b0;
        m1_rdata    = s_rdata;
        m1_rresp    = s_rresp;
        m1_awready  = 1'b0;
        m1_wready   = 1'b0;
        m1_bvalid   = 1'b0;
        m1_bresp    = s_bresp;

        s_arvalid   = 1'b0;
        s_araddr    = m0_araddr;
        s_arsize    = m0_arsize;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_awaddr    = m1_awaddr;
        s_wvalid    = 1'b0;
        s_wdata     = m1_wdata;
        s_wstrb     = m1_wstrb;
        s_bready    = 1'b0;

        busy        = (state != IDLE);
        grant       = 2'b00;

        unique case (state)
            IDLE: begin
                if (pick1) begin
                    last_m1_nxt = 1'b1;
                    state_nxt   = wr1 ? M1_AW : M1_AR;
                end else if (req0) begin
                    last_m1_nxt = 1'b0;
                    state_nxt   = M0_AR;
                end
            end
            M0_AR: begin
                grant      = 2'b01;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
                if (!m0_arvalid)
                    state_nxt = IDLE;
                else if (s_arready)
                    state_nxt = M0_R;
            end
            M0_R: begin
                grant     = 2'b01;
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
                if (s_rvalid && m0_rready)
                    state_nxt = IDLE;
            end
            M1_AR: begin
                grant      = 2'b10;
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                s_arsize   = m1_arsize;
                m1_arready = s_arready;
                if (!m1_arvalid)
                    state_nxt = IDLE;
                else if (s_arready)
                    state_nxt = M1_R;
            end
            M1_R: begin
                grant     = 2'b10;
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
                if (s_rvalid && m1_rready)
                    state_nxt = IDLE;
            end
            M1_AW: begin
                // AW and W may complete on different cycles; the master is acked once both are in
                grant      = 2'b10;
                s_awvalid  = m1_awvalid & ~aw_done;
                s_wvalid   = m1_wvalid & ~w_done;
                aw_ok      = aw_done | (s_awvalid & s_awready);
                w_ok       = w_done | (s_wvalid & s_wready);
                m1_awready = aw_ok & w_ok;
                m1_wready  = aw_ok & w_ok;
                if (aw_ok && w_ok) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = M1_B;
                end else if (!aw_ok && !w_ok && !(m1_awvalid && m1_wvalid)) begin
                    state_nxt = IDLE;
                end else begin
                    aw_done_nxt = aw_ok;
                    w_done_nxt  = w_ok;
                end
            end
            M1_B: begin
                grant     = 2'b10;
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
                if (s_bvalid && m1_bready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: round-robin instance fully checked, a fixed-priority
// instance sharing the same stimulus is checked for its grant order.
module tb_axi_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic              m0_arvalid = 0, m0_rready = 0;
    logic [ADDR_W-1:0] m0_araddr = '0;
    logic [2:0]        m0_arsize = '0;
    logic              m1_arvalid = 0, m1_rready = 0, m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0;
    logic [ADDR_W-1:0] m1_araddr = '0, m1_awaddr = '0;
    logic [2:0]        m1_arsize = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic [3:0]        m1_wstrb = '0;
    logic              s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
    logic [DATA_W-1:0] s_rdata = '0;
    logic [1:0]        s_rresp = '0, s_bresp = '0;

    logic              m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_wdata;
    logic [1:0]        m0_rresp, m1_rresp, m1_bresp, grant;
    logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, busy;
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [2:0]        s_arsize;
    logic [3:0]        s_wstrb;

    logic              f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid, f_m1_awready, f_m1_wready, f_m1_bvalid;
    logic [DATA_W-1:0] f_m0_rdata, f_m1_rdata, f_s_wdata;
    logic [1:0]        f_m0_rresp, f_m1_rresp, f_m1_bresp, f_grant;
    logic              f_s_arvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready, f_busy;
    logic [ADDR_W-1:0] f_s_araddr, f_s_awaddr;
    logic [2:0]        f_s_arsize;
    logic [3:0]        f_s_wstrb;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(1'b1)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .busy(busy), .grant(grant)
    );

    axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(1'b0)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arready(f_m0_arready),
        .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arready(f_m1_arready),
        .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(f_m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(f_m1_wready),
        .m1_bvalid(f_m1_bvalid), .m1_bresp(f_m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(f_s_arvalid), .s_araddr(f_s_araddr), .s_arsize(f_s_arsize), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(f_s_rready),
        .s_awvalid(f_s_awvalid), .s_awaddr(f_s_awaddr), .s_awready(s_awready),
        .s_wvalid(f_s_wvalid), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(f_s_bready),
        .busy(f_busy), .grant(f_grant)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_rready = 0; m1_arvalid = 0; m1_rready = 0;
        m1_awvalid = 0; m1_wvalid = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
        s_rresp = 0; s_bresp = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        reset = 1'b0;
    endtask

    // Full M0 read with a zero-wait slave, starting from an IDLE cycle
    task automatic m0_read(input logic [31:0] addr, input logic [31:0] data, input string tag);
        m0_arvalid = 1; m0_araddr = addr; m0_arsize = 3'd2; s_arready = 1;
        #1;
        check({tag, "_idle_sarvalid"}, s_arvalid, 0);
        tick(); #1;
        check({tag, "_ar_sarvalid"}, s_arvalid, 1);
        check({tag, "_ar_saraddr"}, s_araddr, 64'(addr));
        check({tag, "_ar_m0arready"}, m0_arready, 1);
        check({tag, "_ar_grant"}, grant, 2'b01);
        check({tag, "_ar_busy"}, busy, 1);
        tick();
        m0_arvalid = 0; s_arready = 0;
        s_rvalid = 1; s_rdata = data; s_rresp = 2'b00; m0_rready = 1;
        #1;
        check({tag, "_r_m0rvalid"}, m0_rvalid, 1);
        check({tag, "_r_m0rdata"}, m0_rdata, 64'(data));
        check({tag, "_r_m0rresp"}, m0_rresp, 0);
        check({tag, "_r_srready"}, s_rready, 1);
        check({tag, "_r_m1rvalid"}, m1_rvalid, 0);
        tick();
        s_rvalid = 0; m0_rready = 0;
        #1;
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_m0rvalid"}, m0_rvalid, 0);
    endtask

    initial begin
        // Reset state of both instances with all inputs idle
        tick(); #1;
        check("fp_reset_quiet", |{f_m0_arready, f_m0_rvalid, f_m0_rdata, f_m0_rresp, f_m1_arready,
              f_m1_rvalid, f_m1_rdata, f_m1_rresp, f_m1_awready, f_m1_wready, f_m1_bvalid, f_m1_bresp,
              f_s_arvalid, f_s_araddr, f_s_arsize, f_s_rready, f_s_awvalid, f_s_awaddr, f_s_wvalid,
              f_s_wdata, f_s_wstrb, f_s_bready, f_busy, f_grant}, 0);
        apply_reset();

        // Both masters request continuously; RR alternates M1,M0,M1 while fixed priority stays on M1
        m0_arvalid = 1; m0_araddr = 32'h0000_1000; m1_arvalid = 1; m1_araddr = 32'h0000_2000;
        s_arready = 1; s_rvalid = 1; s_rdata = 32'hCAFE_0000; m0_rready = 1; m1_rready = 1;
        #1;
        check("rr_idle_stray_rready", s_rready, 0);
        check("rr_idle_m0rvalid", m0_rvalid, 0);
        tick(); #1;
        check("rr1_grant", grant, 2'b10);
        check("fp1_grant", f_grant, 2'b10);
        check("rr1_saraddr", s_araddr, 32'h0000_2000);
        check("rr1_m0arready", m0_arready, 0);
        tick(); #1;
        check("rr1_m1rvalid", m1_rvalid, 1);
        check("rr1_m0rvalid", m0_rvalid, 0);
        tick(); #1;
        check("rr_gap_busy", busy, 0);
        check("rr_gap_srready", s_rready, 0);
        tick(); #1;
        check("rr2_grant", grant, 2'b01);
        check("fp2_grant", f_grant, 2'b10);
        check("rr2_saraddr", s_araddr, 32'h0000_1000);
        tick(); #1;
        check("rr2_m0rvalid", m0_rvalid, 1);
        check("rr2_m1rvalid", m1_rvalid, 0);
        tick(); tick(); #1;
        check("rr3_grant", grant, 2'b10);
        check("fp3_grant", f_grant, 2'b10);
        clear_inputs();
        apply_reset();

        m0_read(32'h8000_0000, 32'h1234_5678, "rd0");

        // M1 write with a read also pending: write wins; AW taken first, W two cycles later
        m1_arvalid = 1; m1_araddr = 32'h0000_3000;
        m1_awvalid = 1; m1_awaddr = 32'h0200_0004;
        m1_wvalid = 1; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'hF;
        s_awready = 1; s_wready = 0;
        #1;
        check("wr_idle_sawvalid", s_awvalid, 0);
        tick();
        m1_arvalid = 0;
        #1;
        check("wr_n_sawvalid", s_awvalid, 1);
        check("wr_n_sawaddr", s_awaddr, 32'h0200_0004);
        check("wr_n_sarvalid", s_arvalid, 0);
        check("wr_n_grant", grant, 2'b10);
        check("wr_n_m1ready", {m1_awready, m1_wready}, 2'b00);
        tick(); #1;
        check("wr_n1_sawvalid", s_awvalid, 0);
        check("wr_n1_swvalid", s_wvalid, 1);
        check("wr_n1_m1ready", {m1_awready, m1_wready}, 2'b00);
        tick();
        s_wready = 1;
        #1;
        check("wr_n2_m1ready", {m1_awready, m1_wready}, 2'b11);
        check("wr_n2_swdata", s_wdata, 32'hAABB_CCDD);
        check("wr_n2_swstrb", s_wstrb, 4'hF);
        tick();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b01; m1_bready = 1;
        #1;
        check("wr_b_m1bvalid", m1_bvalid, 1);
        check("wr_b_m1bresp", m1_bresp, 2'b01);
        check("wr_b_sbready", s_bready, 1);
        check("wr_b_sawvalid", s_awvalid, 0);
        tick();
        s_bvalid = 0; m1_bready = 0;
        #1;
        check("wr_done_busy", busy, 0);
        check("wr_done_m1bvalid", m1_bvalid, 0);

        // Second write, then reset while the B response is pending
        m1_awvalid = 1; m1_awaddr = 32'h0200_0008; m1_wvalid = 1; m1_wdata = 32'h0F0F_0F0F;
        s_awready = 1; s_wready = 1;
        tick(); #1;
        check("wr2_m1awready", m1_awready, 1);
        tick();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; m1_bready = 0;
        #1;
        check("wr2_b_m1bvalid", m1_bvalid, 1);
        reset = 1;
        tick(); #1;
        check("rstb_m1bvalid", m1_bvalid, 0);
        check("rstb_sbready", s_bready, 0);
        check("rstb_busy", busy, 0);
        check("rstb_grant", grant, 0);
        reset = 0; s_bvalid = 0;
        m0_read(32'h8000_0010, 32'hDEAD_BEEF, "rd1");

        // M0 withdraws its read before the slave accepts it
        m0_arvalid = 1; m0_araddr = 32'h8000_0020; s_arready = 0;
        tick(); #1;
        check("fl_sarvalid", s_arvalid, 1);
        check("fl_m0arready", m0_arready, 0);
        m0_arvalid = 0;
        #1;
        check("fl_drop_sarvalid", s_arvalid, 0);
        tick(); #1;
        check("fl_busy", busy, 0);
        check("fl_grant", grant, 0);

        // M1 read with SLVERR response passed through untouched
        m1_arvalid = 1; m1_araddr = 32'h0000_4000; m1_arsize = 3'd2; s_arready = 1;
        tick(); #1;
        check("er_grant", grant, 2'b10);
        check("er_saraddr", s_araddr, 32'h0000_4000);
        check("er_m1arready", m1_arready, 1);
        tick();
        m1_arvalid = 0; s_arready = 0;
        s_rvalid = 1; s_rdata = 32'h5555_AAAA; s_rresp = 2'b10; m1_rready = 1;
        #1;
        check("er_m1rvalid", m1_rvalid, 1);
        check("er_m1rresp", m1_rresp, 2'b10);
        check("er_m1rdata", m1_rdata, 32'h5555_AAAA);
        check("er_m0rvalid", m0_rvalid, 0);
        tick();
        s_rvalid = 0; m1_rready = 0;
        #1;
        check("er_done_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
